// File: rtl/irq_inj_pkg.sv
// Shared types and constants for the interrupt injector.
// Feature macro IRQ_INJ_REARM_EN (rearm input) is consumed in irq_injector.sv.
package irq_inj_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_PULSE   = 2'd2
   } inj_state_t;

   localparam int CNT_W         = 16;
   localparam int PULSE_LEN_MIN = 1;
   localparam int PULSE_LEN_MAX = 255;
   localparam int PULSE_CNT_W   = 8;

   // Index width that stays legal when a parameter is 1.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int clamp_len(input int len);
      if (len < PULSE_LEN_MIN) return PULSE_LEN_MIN;
      if (len > PULSE_LEN_MAX) return PULSE_LEN_MAX;
      return len;
   endfunction

endpackage

// File: rtl/irq_pulse_gen.sv
// Registered one-hot pulse of fixed length on a selected line; done flags the last cycle.
module irq_pulse_gen
   import irq_inj_pkg::*;
#(
   parameter int NUM_IRQ   = 6,
   parameter int CH_W      = 3,
   parameter int PULSE_LEN = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [CH_W-1:0]    chan,
   output logic [NUM_IRQ-1:0] irq,
   output logic               done
);

   localparam int LEN = clamp_len(PULSE_LEN);

   logic [PULSE_CNT_W-1:0] cnt;
   logic                   active;

   // active is kept separately so a channel outside NUM_IRQ still terminates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq    <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (load) begin
         irq    <= NUM_IRQ'(1) << chan;
         cnt    <= PULSE_CNT_W'(LEN - 1);
         active <= 1'b1;
      end else if (active) begin
         if (cnt == '0) begin
            irq    <= '0;
            active <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign done = active && (cnt == '0);

endmodule

// File: rtl/irq_injector.sv
// Injects a one-shot interrupt pulse when the processor PC passes a programmed watch address.
// Optional macro IRQ_INJ_REARM_EN adds the rearm input.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | watching pc_addr against armed entries
//   ST_PENDING | entry captured, waiting for pc_addr to leave its address
//   ST_PULSE   | irq line high for PULSE_LEN cycles
module irq_injector
   import irq_inj_pkg::*;
#(
   parameter int NUM_WATCH = 5,
   parameter int NUM_IRQ   = 6,
   parameter int PULSE_LEN = 6
) (
   input  logic                               clk,
   input  logic                               reset,
`ifdef IRQ_INJ_REARM_EN
   input  logic                               rearm,
`endif
   input  logic [31:0]                        pc_addr,
   input  logic                               cfg_we,
   input  logic [idx_width(NUM_WATCH)-1:0]    cfg_idx,
   input  logic [31:0]                        cfg_addr,
   input  logic [idx_width(NUM_IRQ)-1:0]      cfg_chan,
   output logic [NUM_IRQ-1:0]                 irq,
   output logic                               busy,
   output logic [CNT_W-1:0]                   fire_cnt
);

   localparam int IDX_W = idx_width(NUM_WATCH);
   localparam int CH_W  = idx_width(NUM_IRQ);

   logic [31:0]          entry_addr [NUM_WATCH];
   logic [CH_W-1:0]      entry_chan [NUM_WATCH];
   logic [NUM_WATCH-1:0] armed;
   logic [NUM_WATCH-1:0] armed_nxt;

   inj_state_t      state;
   logic [31:0]     lat_addr;
   logic [CH_W-1:0] lat_chan;

   logic            cfg_wr;
   logic            hit;
   logic [IDX_W-1:0] hit_idx;
   logic            capture;
   logic            load;
   logic            pulse_done;

   assign cfg_wr = cfg_we && (32'(cfg_idx) < NUM_WATCH);

   // Descending scan so the lowest matching index wins; an entry being
   // written this cycle is excluded so the write takes priority.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_WATCH - 1; i >= 0; i--) begin
         if (armed[i] && (entry_addr[i] == pc_addr) &&
             !(cfg_wr && (cfg_idx == IDX_W'(i)))) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   assign capture = (state == ST_IDLE) && hit;
   assign load    = (state == ST_PENDING) && (pc_addr != lat_addr);

`ifdef IRQ_INJ_REARM_EN
   logic [NUM_WATCH-1:0] written;
   logic [NUM_WATCH-1:0] written_nxt;
`endif

   always_comb begin
      armed_nxt = armed;
`ifdef IRQ_INJ_REARM_EN
      written_nxt = written;
`endif
      if (capture) armed_nxt[hit_idx] = 1'b0;
      if (cfg_wr) begin
         armed_nxt[cfg_idx] = 1'b1;
`ifdef IRQ_INJ_REARM_EN
         written_nxt[cfg_idx] = 1'b1;
`endif
      end
`ifdef IRQ_INJ_REARM_EN
      if (rearm) armed_nxt = armed_nxt | written_nxt;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_WATCH; i++) begin
            entry_addr[i] <= '0;
            entry_chan[i] <= '0;
         end
         armed <= '0;
      end else begin
         armed <= armed_nxt;
         if (cfg_wr) begin
            entry_addr[cfg_idx] <= cfg_addr;
            entry_chan[cfg_idx] <= cfg_chan;
         end
      end
   end

`ifdef IRQ_INJ_REARM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) written <= '0;
      else        written <= written_nxt;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         lat_addr <= '0;
         lat_chan <= '0;
         fire_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (capture) begin
                  lat_addr <= entry_addr[hit_idx];
                  lat_chan <= entry_chan[hit_idx];
                  state    <= ST_PENDING;
                  busy     <= 1'b1;
               end
            end
            ST_PENDING: begin
               if (load) begin
                  state <= ST_PULSE;
                  if (fire_cnt != '1) fire_cnt <= fire_cnt + 1'b1;
               end
            end
            ST_PULSE: begin
               if (pulse_done) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   irq_pulse_gen #(
      .NUM_IRQ   (NUM_IRQ),
      .CH_W      (CH_W),
      .PULSE_LEN (PULSE_LEN)
   ) u_pulse (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .chan  (lat_chan),
      .irq   (irq),
      .done  (pulse_done)
   );

endmodule

// File: tb/tb_irq_injector.sv
// Self-checking bench for irq_injector: directed table, corner sequences, random vs reference model.
module tb_irq_injector;

   localparam int NW = 5;
   localparam int NI = 6;
   localparam int PL = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rearm = 1'b0;
   logic [31:0] pc_addr = '0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_idx = '0;
   logic [31:0] cfg_addr = '0;
   logic [2:0]  cfg_chan = '0;
   logic [5:0]  irq;
   logic        busy;
   logic [15:0] fire_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_injector #(.NUM_WATCH(NW), .NUM_IRQ(NI), .PULSE_LEN(PL)) dut (
      .clk      (clk),
      .reset    (reset),
`ifdef IRQ_INJ_REARM_EN
      .rearm    (rearm),
`endif
      .pc_addr  (pc_addr),
      .cfg_we   (cfg_we),
      .cfg_idx  (cfg_idx),
      .cfg_addr (cfg_addr),
      .cfg_chan (cfg_chan),
      .irq      (irq),
      .busy     (busy),
      .fire_cnt (fire_cnt)
   );

   // Reference model: watch table plus "pending" flag and remaining pulse cycles.
   logic [31:0] m_addr [NW];
   int          m_chan [NW];
   bit          m_armed [NW];
   bit          m_written [NW];
   bit          m_pending;
   logic [31:0] m_lat_addr;
   int          m_lat_chan;
   int          m_left;
   int          m_fire;

   task automatic model_reset();
      for (int i = 0; i < NW; i++) begin
         m_addr[i] = '0; m_chan[i] = 0; m_armed[i] = 0; m_written[i] = 0;
      end
      m_pending = 0; m_lat_addr = '0; m_lat_chan = 0; m_left = 0; m_fire = 0;
   endtask

   task automatic model_step(input bit we, input int idx, input logic [31:0] addr,
                             input int chan, input logic [31:0] pc, input bit rr);
      bit was_idle = !m_pending && (m_left == 0);
      bit was_pend = m_pending;
      if (m_left > 0) m_left--;
      if (was_pend && pc != m_lat_addr) begin
         m_pending = 0;
         m_left    = PL;
         if (m_fire < 65535) m_fire++;
      end
      if (was_idle) begin
         for (int i = 0; i < NW; i++) begin
            if (m_armed[i] && m_addr[i] == pc && !(we && idx == i)) begin
               m_pending  = 1;
               m_lat_addr = m_addr[i];
               m_lat_chan = m_chan[i];
               m_armed[i] = 0;
               break;
            end
         end
      end
      if (we && idx < NW) begin
         m_addr[idx] = addr; m_chan[idx] = chan;
         m_armed[idx] = 1; m_written[idx] = 1;
      end
      if (rr) for (int i = 0; i < NW; i++) if (m_written[i]) m_armed[i] = 1;
   endtask

   function automatic logic [5:0] m_irq();
      logic [5:0] v;
      v = '0;
      if (m_left > 0) v[m_lat_chan] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit we, input int idx, input logic [31:0] addr,
                      input int chan, input logic [31:0] pc, input bit rr);
      bit rr_eff;
`ifdef IRQ_INJ_REARM_EN
      rr_eff = rr;
`else
      rr_eff = 1'b0;
`endif
      @(negedge clk);
      cfg_we = we; cfg_idx = 3'(idx); cfg_addr = addr; cfg_chan = 3'(chan);
      pc_addr = pc; rearm = rr_eff;
      @(posedge clk);
      model_step(we, idx, addr, chan, pc, rr_eff);
      #1;
      chk("irq",  32'(irq),      32'(m_irq()));
      chk("busy", 32'(busy),     32'(m_pending || m_left > 0));
      chk("fire", 32'(fire_cnt), 32'(m_fire));
   endtask

   task automatic idle_pc(input logic [31:0] pc, input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, pc, 0);
   endtask

   typedef struct {
      bit          we;
      int          idx;
      logic [31:0] addr;
      int          chan;
      logic [31:0] pc;
      logic [5:0]  e_irq;
      bit          e_busy;
      int          e_fire;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // watch 0x301c on channel 2, dwell three cycles, move on, then revisit
      tbl[0]  = '{1, 0, 32'h301c, 2, 32'h0,    6'h00, 0, 0};
      tbl[1]  = '{0, 0, 32'h0,    0, 32'h301c, 6'h00, 1, 0};
      tbl[2]  = '{0, 0, 32'h0,    0, 32'h301c, 6'h00, 1, 0};
      tbl[3]  = '{0, 0, 32'h0,    0, 32'h301c, 6'h00, 1, 0};
      tbl[4]  = '{0, 0, 32'h0,    0, 32'h3020, 6'h04, 1, 1};
      tbl[5]  = '{0, 0, 32'h0,    0, 32'h3020, 6'h04, 1, 1};
      tbl[6]  = '{0, 0, 32'h0,    0, 32'h3020, 6'h04, 1, 1};
      tbl[7]  = '{0, 0, 32'h0,    0, 32'h3020, 6'h04, 1, 1};
      tbl[8]  = '{0, 0, 32'h0,    0, 32'h3020, 6'h04, 1, 1};
      tbl[9]  = '{0, 0, 32'h0,    0, 32'h3020, 6'h04, 1, 1};
      tbl[10] = '{0, 0, 32'h0,    0, 32'h3020, 6'h00, 0, 1};
      tbl[11] = '{0, 0, 32'h0,    0, 32'h301c, 6'h00, 0, 1};
      tbl[12] = '{0, 0, 32'h0,    0, 32'h3020, 6'h00, 0, 1};

      model_reset();
      #12;
      chk("rst_irq",  32'(irq), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fire", 32'(fire_cnt), 0);
      @(negedge clk);
      reset = 1'b1;

      for (int r = 0; r < 13; r++) begin
         cyc(tbl[r].we, tbl[r].idx, tbl[r].addr, tbl[r].chan, tbl[r].pc, 0);
         chk($sformatf("tbl%0d_irq", r),  32'(irq),      32'(tbl[r].e_irq));
         chk($sformatf("tbl%0d_busy", r), 32'(busy),     32'(tbl[r].e_busy));
         chk($sformatf("tbl%0d_fire", r), 32'(fire_cnt), 32'(tbl[r].e_fire));
      end

`ifdef IRQ_INJ_REARM_EN
      cyc(0, 0, 0, 0, 32'h0, 1);
      cyc(0, 0, 0, 0, 32'h301c, 0);
      cyc(0, 0, 0, 0, 32'h3020, 0);
      chk("rearm_irq",  32'(irq), 32'h04);
      chk("rearm_fire", 32'(fire_cnt), 2);
      idle_pc(32'h0, PL);
`endif

      // two entries on the same address: lowest index wins, the other stays armed
      cyc(1, 1, 32'h30ac, 0, 32'h0, 0);
      cyc(1, 3, 32'h30ac, 5, 32'h0, 0);
      cyc(0, 0, 0, 0, 32'h30ac, 0);
      cyc(0, 0, 0, 0, 32'h30b0, 0);
      chk("dup_low_irq", 32'(irq), 32'h01);
      idle_pc(32'h30b0, PL);
      cyc(0, 0, 0, 0, 32'h30ac, 0);
      cyc(0, 0, 0, 0, 32'h30b0, 0);
      chk("dup_high_irq", 32'(irq), 32'h20);
      idle_pc(32'h30b0, PL);

      // jump to another armed address while pending: not captured, fires later
      cyc(1, 2, 32'h3108, 1, 32'h0, 0);
      cyc(1, 4, 32'h31c0, 3, 32'h0, 0);
      cyc(0, 0, 0, 0, 32'h3108, 0);
      cyc(0, 0, 0, 0, 32'h31c0, 0);
      chk("pend_jump_irq", 32'(irq), 32'h02);
      idle_pc(32'h0, PL);
      cyc(0, 0, 0, 0, 32'h31c0, 0);
      cyc(0, 0, 0, 0, 32'h0, 0);
      chk("later_fire_irq", 32'(irq), 32'h08);
      idle_pc(32'h0, PL);

      // write collides with a match on the entry's old address
      cyc(1, 0, 32'h5000, 4, 32'h0, 0);
      cyc(1, 0, 32'h6000, 1, 32'h5000, 0);
      chk("wr_prio_busy", 32'(busy), 0);
      cyc(0, 0, 0, 0, 32'h6000, 0);
      cyc(0, 0, 0, 0, 32'h0, 0);
      chk("wr_prio_irq", 32'(irq), 32'h02);
      idle_pc(32'h0, PL);

      // out-of-range index is ignored
      cyc(1, 6, 32'h7700, 0, 32'h0, 0);
      cyc(0, 0, 0, 0, 32'h7700, 0);
      chk("oor_busy", 32'(busy), 0);

      // asynchronous reset in the third pulse cycle
      cyc(1, 1, 32'h7000, 3, 32'h0, 0);
      cyc(0, 0, 0, 0, 32'h7000, 0);
      idle_pc(32'h0, 3);
      chk("pre_rst_irq", 32'(irq), 32'h08);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_irq",  32'(irq), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_fire", 32'(fire_cnt), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      cyc(0, 0, 0, 0, 32'h7000, 0);
      cyc(0, 0, 0, 0, 32'h30ac, 0);
      cyc(0, 0, 0, 0, 32'h31c0, 0);
      cyc(0, 0, 0, 0, 32'h0, 0);
      chk("post_rst_busy", 32'(busy), 0);

      // randomized traffic over a small address pool
      for (int n = 0; n < 600; n++) begin
         logic [31:0] pc;
         bit we, rr;
         pc = 32'h100 + 32'($urandom_range(0, 3)) * 4;
         we = ($urandom_range(0, 7) == 0);
         rr = ($urandom_range(0, 19) == 0);
         cyc(we, $urandom_range(0, 7), 32'h100 + 32'($urandom_range(0, 3)) * 4,
             $urandom_range(0, 5), pc, rr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_injector.md
IRQ_INJECTOR -- requirements
Module: irq_injector

Interface
REQ-001 SHALL have parameter NUM_WATCH, default 5, number of programmable watch-address entries (1..16).
REQ-002 SHALL have parameter NUM_IRQ, default 6, number of interrupt output lines (1..8).
REQ-003 SHALL have parameter PULSE_LEN, default 6, cycles each injected interrupt stays high (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-006 SHALL have port pc_addr  input  32  instruction address of the processor under test.
REQ-007 SHALL have port cfg_we  input  1  write strobe for one watch entry.
REQ-008 SHALL have port cfg_idx  input  clog2(NUM_WATCH)  entry index written.
REQ-009 SHALL have port cfg_addr  input  32  trigger address for the entry.
REQ-010 SHALL have port cfg_chan  input  clog2(NUM_IRQ)  output line the entry drives.
REQ-011 SHALL have port irq  output  NUM_IRQ  one-hot interrupt lines to the processor.
REQ-012 SHALL have port busy  output  1  high in PENDING or PULSE.
REQ-013 SHALL have port fire_cnt  output  16  total injected pulses since reset, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, PENDING, PULSE.
REQ-015 Writing with cfg_we SHALL load addr/chan into entry cfg_idx and set its armed bit; out-of-range cfg_idx ignored.
REQ-016 IDLE: if pc_addr equals an armed entry's addr, SHALL latch that entry's addr and chan, clear its armed bit, go PENDING next cycle.
REQ-017 Multiple armed entries matching in the same cycle SHALL resolve to lowest index; the others stay armed.
REQ-018 PENDING: when pc_addr differs from the latched addr, SHALL go PULSE; while equal, SHALL remain PENDING.
REQ-019 PENDING: a match on another armed entry SHALL NOT be captured; that entry stays armed.
REQ-020 PULSE: irq[latched chan] SHALL be 1 for exactly PULSE_LEN cycles starting the cycle after leaving PENDING, then return to IDLE.
REQ-021 PULSE: pc_addr matches SHALL be ignored; entries keep their armed state.
REQ-022 irq SHALL be registered, at most one bit high, 0 outside PULSE.
REQ-023 fire_cnt SHALL increment on PENDING->PULSE and saturate at 16'hFFFF.
REQ-024 cfg_we in the same cycle as a match on that entry SHALL give the write priority: new values loaded, entry armed, no capture.
REQ-025 cfg_we during PENDING/PULSE SHALL update the table without disturbing the in-flight pulse.

Reset
REQ-026 While reset=0: state IDLE, irq=0, busy=0, fire_cnt=0, all armed bits 0, entry addr/chan 0, pulse counter 0.
REQ-027 Reset asserted mid-PULSE SHALL drop irq to 0 asynchronously.
REQ-028 First capture possible on the second rising edge after reset deasserts.

Configuration
REQ-029 Macro IRQ_INJ_REARM_EN SHALL add input port rearm (1 bit); when defined, rearm=1 for one cycle re-arms every entry previously written since reset. Same-cycle capture completes first, then re-arm applies.
REQ-030 Without IRQ_INJ_REARM_EN: no rearm port; each entry fires at most once per write.

Structure
REQ-031 Package irq_inj_pkg SHALL hold the FSM state enum, the 16-bit counter width constant, and the PULSE_LEN range limits.
REQ-032 Sub-module irq_pulse_gen (load, chan -> registered one-hot irq, down-counter, done) SHALL implement the PULSE timing; all other logic is top level.

Verification
REQ-033 Write entry0 {0x301c, chan 2}, pc 0x301c for 3 cycles then 0x3020 -> irq[2] high 6 cycles starting the cycle after the change; fire_cnt=1.
REQ-034 Revisit 0x301c after firing -> no pulse; with IRQ_INJ_REARM_EN, pulse rearm then revisit -> second pulse, fire_cnt=2.
REQ-035 Entries 1={0x30ac,ch0} and 3={0x30ac,ch5}, pc 0x30ac then 0x30b0 -> irq[0] only; entry3 armed; revisit 0x30ac -> irq[5].
REQ-036 Pending on 0x3108, pc jumps to armed 0x31c0 -> pulse from 0x3108's channel only; 0x31c0 stays armed, fires on its next visit.
REQ-037 Reset low at PULSE cycle 3 -> irq=0 immediately, fire_cnt=0, all entries disarmed.
REQ-038 cfg_we to entry0 in the same cycle pc_addr hits its old addr -> no capture, entry0 holds new addr and is armed.
